// File: rtl/interboard_send_pkg.sv
// Shared types and helpers for the inter-board message transmitter.
// Optional build macro: INTERBOARD_PARITY_EN (adds an even-parity bit as inter_data[8]).
package interboard_send_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_SETUP  = 3'd1,
    TX_REQ_HI = 3'd2,
    TX_REQ_LO = 3'd3,
    TX_DONE   = 3'd4
  } tx_state_e;

`ifdef INTERBOARD_PARITY_EN
  localparam int INTERBOARD_DATA_W = 9;
`else
  localparam int INTERBOARD_DATA_W = 8;
`endif

  function automatic logic [INTERBOARD_DATA_W-1:0] make_word(input logic [2:0] msg_type,
                                                              input logic [4:0] number);
`ifdef INTERBOARD_PARITY_EN
    return {^{msg_type, number}, msg_type, number};
`else
    return {msg_type, number};
`endif
  endfunction

endpackage

// File: rtl/interboard_send_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous bit; all stages clear to 0 on reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= {sr_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sr_q[STAGES-1];

endmodule

// File: rtl/interboard_send.sv
// Board-to-board transmitter: latches one {msg_type, number} word and sends it with a 4-phase req/ack.
// Optional build macro: INTERBOARD_PARITY_EN widens inter_data to 9 bits with even parity in bit 8.
module interboard_send
  import interboard_send_pkg::*;
#(
  parameter int SETUP_CYCLES = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         interboard_rst,
  input  logic                         ctrl_en,
  input  logic [2:0]                   ctrl_msg_type,
  input  logic [4:0]                   ctrl_number,
  input  logic                         transmit,
  input  logic                         inter_ack,
  output logic                         inter_req,
  output logic [INTERBOARD_DATA_W-1:0] inter_data,
  output logic                         inter_ready,
  output logic                         busy,
  output logic                         overrun
);

  localparam int CNT_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETUP_CYCLES - 1);

  tx_state_e                    state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         req_q, req_d;
  logic [INTERBOARD_DATA_W-1:0] data_q, data_d;
  logic                         ovr_q, ovr_d;
  logic                         ack_s;
  logic                         clr;

  // transmit is status-only; the transfer never depends on it
  logic unused_transmit;
  assign unused_transmit = transmit;

  assign clr = rst | interboard_rst;

  sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (clr),
    .d_i (inter_ack),
    .q_o (ack_s)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    data_d  = data_q;
    ovr_d   = ctrl_en && (state_q != TX_IDLE);
    unique case (state_q)
      TX_IDLE: begin
        if (ctrl_en) begin
          data_d  = make_word(ctrl_msg_type, ctrl_number);
          cnt_d   = '0;
          state_d = TX_SETUP;
        end
      end
      TX_SETUP: begin
        // A stale ack from the peer parks us at the terminal count until it clears
        if (cnt_q == CNT_LAST) begin
          if (!ack_s) begin
            req_d   = 1'b1;
            state_d = TX_REQ_HI;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_REQ_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = TX_REQ_LO;
        end
      end
      TX_REQ_LO: begin
        if (!ack_s) begin
          state_d = TX_DONE;
        end
      end
      TX_DONE: begin
        state_d = TX_IDLE;
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  assign inter_req   = req_q;
  assign inter_data  = data_q;
  assign inter_ready = (state_q == TX_DONE);
  assign busy        = (state_q != TX_IDLE);
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_interboard_send.sv
// Scoreboard bench for interboard_send: directed sends with a behavioural peer on the cable.
module tb_interboard_send;
  import interboard_send_pkg::*;

  localparam int SETUP_CYCLES = 4;
  localparam int SYNC_STAGES  = 2;
  localparam int DW           = INTERBOARD_DATA_W;
  localparam int ACK_DLY      = 3;
  localparam logic [2:0] SEL_NUM   = 3'd1;
  localparam logic [2:0] STATE_WIN = 3'd5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          interboard_rst = 1'b0;
  logic          ctrl_en = 1'b0;
  logic [2:0]    ctrl_msg_type = '0;
  logic [4:0]    ctrl_number = '0;
  logic          transmit = 1'b0;
  logic          inter_ack = 1'b0;
  logic          inter_req;
  logic [DW-1:0] inter_data;
  logic          inter_ready;
  logic          busy;
  logic          overrun;

  int tests = 0;
  int fails = 0;
  int ovr_seen = 0;
  int ovr_exp = 0;
  bit peer_en = 1'b1;
  logic [DW-1:0] exp_q[$];

  interboard_send #(.SETUP_CYCLES(SETUP_CYCLES), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk            (clk),
    .rst            (rst),
    .interboard_rst (interboard_rst),
    .ctrl_en        (ctrl_en),
    .ctrl_msg_type  (ctrl_msg_type),
    .ctrl_number    (ctrl_number),
    .transmit       (transmit),
    .inter_ack      (inter_ack),
    .inter_req      (inter_req),
    .inter_data     (inter_data),
    .inter_ready    (inter_ready),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_word(input logic [2:0] t, input logic [4:0] n);
    logic [7:0] w;
    logic       p;
    w = {t, n};
    p = 1'b0;
    for (int i = 0; i < 8; i++) p = p ^ w[i];
    if (DW == 9) return DW'({p, w});
    return DW'(w);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [2:0] t, input logic [4:0] n);
    @(negedge clk);
    ctrl_msg_type = t;
    ctrl_number   = n;
    ctrl_en       = 1'b1;
    @(negedge clk);
    ctrl_en       = 1'b0;
  endtask

  task automatic wait_req(output int lat);
    lat = 1;
    while (!inter_req && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (busy && i < 300) begin
      @(negedge clk);
      i++;
    end
    check(name, {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Peer: mirrors inter_req onto inter_ack after ACK_DLY clocks
  initial begin
    int dly;
    dly = 0;
    forever begin
      @(posedge clk);
      #1;
      if (peer_en) begin
        if (inter_req != inter_ack) begin
          if (dly >= ACK_DLY) begin
            inter_ack = inter_req;
            dly = 0;
          end else begin
            dly++;
          end
        end else begin
          dly = 0;
        end
      end else begin
        dly = 0;
      end
    end
  end

  // Monitor: every inter_ready must match the oldest accepted word
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (overrun) ovr_seen++;
      if (inter_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 32'(inter_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("ready_data", 32'(inter_data), 32'(e));
        end
      end
    end
  end

  initial begin
    int lat;
    bit saw;

    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, inter_req}, 32'd0);
    check("rst_data", 32'(inter_data), 32'd0);
    check("rst_ready", {31'd0, inter_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    transmit = 1'b1;

    // 1: basic send, latency from strobe cycle to req
    exp_q.push_back(exp_word(SEL_NUM, 5'd17));
    strobe(SEL_NUM, 5'd17);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_req(lat);
    check("t1_latency", 32'(lat), 32'(SETUP_CYCLES + 1));
    check("t1_data", 32'(inter_data), 32'(exp_word(SEL_NUM, 5'd17)));
    wait_idle("t1_idle");

    // 2: strobe during REQ_HI is dropped and flagged
    exp_q.push_back(exp_word(SEL_NUM, 5'd17));
    strobe(SEL_NUM, 5'd17);
    wait_req(lat);
    ovr_exp++;
    strobe(SEL_NUM, 5'd3);
    check("t2_data_held", 32'(inter_data), 32'(exp_word(SEL_NUM, 5'd17)));
    transmit = 1'b0;
    wait_idle("t2_idle");
    transmit = 1'b1;

    // 3: reset during REQ_HI with ack high aborts at once
    peer_en = 1'b0;
    strobe(3'd2, 5'd21);
    wait_req(lat);
    inter_ack = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("t3_req", {31'd0, inter_req}, 32'd0);
    check("t3_busy", {31'd0, busy}, 32'd0);
    check("t3_data", 32'(inter_data), 32'd0);
    rst = 1'b0;
    inter_ack = 1'b0;
    peer_en = 1'b1;
    exp_q.push_back(exp_word(3'd2, 5'd4));
    strobe(3'd2, 5'd4);
    wait_idle("t3_idle");

    // 4: soft clear from peer while in SETUP
    strobe(3'd6, 5'd11);
    interboard_rst = 1'b1;
    @(negedge clk);
    interboard_rst = 1'b0;
    check("t4_busy", {31'd0, busy}, 32'd0);
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (inter_req) saw = 1'b1;
    end
    check("t4_no_req", {31'd0, saw}, 32'd0);

    // 5: stale ack held before the strobe parks the FSM in SETUP
    peer_en = 1'b0;
    inter_ack = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back(exp_word(3'd7, 5'd25));
    strobe(3'd7, 5'd25);
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (inter_req) saw = 1'b1;
    end
    check("t5_req_low", {31'd0, saw}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd1);
    inter_ack = 1'b0;
    peer_en = 1'b1;
    wait_idle("t5_idle");

    // Out-of-range number passes through; strobe in DONE cycle is an overrun
    exp_q.push_back(exp_word(3'd4, 5'd31));
    strobe(3'd4, 5'd31);
    lat = 0;
    while (!inter_ready && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", {31'd0, inter_ready}, 32'd1);
    ctrl_msg_type = 3'd1;
    ctrl_number   = 5'd2;
    ctrl_en       = 1'b1;
    ovr_exp++;
    @(negedge clk);
    ctrl_en = 1'b0;
    check("done_ovr_busy", {31'd0, busy}, 32'd0);
    check("done_ovr_data", 32'(inter_data), 32'(exp_word(3'd4, 5'd31)));

    // 6: parity word (bit 8 present only in the parity build)
    exp_q.push_back(exp_word(STATE_WIN, 5'd0));
    strobe(STATE_WIN, 5'd0);
    check("t6_data", 32'(inter_data), 32'(exp_word(STATE_WIN, 5'd0)));
    wait_idle("t6_idle");

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("overrun_count", 32'(ovr_seen), 32'(ovr_exp));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
